// File: rtl/gray_count_ctrl.sv
// rtl/gray_count_ctrl.sv - button-driven sequencer producing enable/clear pulses for the Gray counter
// Modes: manual step, prescaled free-run, bounded burst, clear after burst.
module gray_count_ctrl #(
  parameter int N     = 8,
  parameter int DIV   = 1000000,
  parameter int DIV_W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_step,
  input  logic         btn_mode,
  input  logic [N-1:0] run_len,
  output logic         count_en,
  output logic         count_clr,
  output logic         running,
  output logic         done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [DIV_W-1:0] r_presc;
  logic [DIV_W-1:0] w_presc_nxt;
  logic [N-1:0]     r_burst;
  logic [N-1:0]     w_burst_nxt;
  logic [N-1:0]     r_len;
  logic [N-1:0]     w_len_nxt;
  logic             r_step_q;
  logic             r_mode_q;
  logic             r_en;
  logic             r_clr;
  logic             r_running;
  logic             r_done;
  logic             w_step_ev;
  logic             w_mode_ev;
  logic             w_wrap;
  logic             w_term;
  logic             w_en_nxt;
  logic             w_clr_nxt;

  assign w_step_ev = btn_step & ~r_step_q;
  assign w_mode_ev = btn_mode & ~r_mode_q;
  assign w_wrap    = (r_presc == DIV_W'(DIV - 1));
  // Terminal burst count is acted on the cycle after the last pulse.
  assign w_term    = (r_len != '0) && (r_burst == r_len);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_burst   <= '0;
      r_len     <= '0;
      r_step_q  <= 1'b1;
      r_mode_q  <= 1'b1;
      r_en      <= 1'b0;
      r_clr     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_presc   <= w_presc_nxt;
      r_burst   <= w_burst_nxt;
      r_len     <= w_len_nxt;
      r_step_q  <= btn_step;
      r_mode_q  <= btn_mode;
      r_en      <= w_en_nxt;
      r_clr     <= w_clr_nxt;
      r_running <= (w_next == S_RUN);
      r_done    <= (w_next == S_DONE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_mode_ev) w_next = S_RUN;
      S_RUN: begin
        if (w_mode_ev)   w_next = S_IDLE;
        else if (w_term) w_next = S_DONE;
      end
      S_DONE: if (w_mode_ev || w_step_ev) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_presc_nxt = r_presc;
    w_burst_nxt = r_burst;
    w_len_nxt   = r_len;
    w_en_nxt    = 1'b0;
    w_clr_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mode_ev) begin
          w_len_nxt   = run_len;
          w_presc_nxt = '0;
          w_burst_nxt = '0;
        end else if (w_step_ev) begin
          w_en_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (w_mode_ev) begin
          w_presc_nxt = '0;
        end else if (!w_term) begin
          if (w_wrap) begin
            w_presc_nxt = '0;
            w_burst_nxt = r_burst + N'(1);
            w_en_nxt    = 1'b1;
          end else begin
            w_presc_nxt = r_presc + DIV_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!w_mode_ev && w_step_ev) w_clr_nxt = 1'b1;
      end
      default: begin
        w_presc_nxt = '0;
        w_burst_nxt = '0;
      end
    endcase
  end

  assign count_en  = r_en;
  assign count_clr = r_clr;
  assign running   = r_running;
  assign done      = r_done;

endmodule

// File: doc/gray_count_ctrl.md
Name: gray_count_ctrl

Overview:
- Sequencing controller for the N-bit Gray counter datapath. It sits between the debounced push-button outputs and the counter's enable/clear inputs.
- Turns button presses into counter commands:
  - manual single-step,
  - free-running at a prescaled rate,
  - bounded bursts of a programmed length,
  - counter clear.
- Replaces the direct button-to-enable connection, so the counter advances under FSM control only.

Parameters:
- N, 8, width of the burst-length input and the internal burst counter. Matches the Gray counter width.
- DIV, 1000000, clock cycles between enable pulses in RUN. Legal range 2..2^DIV_W-1.
- DIV_W, 20, width of the prescaler counter. Must satisfy 2^DIV_W > DIV.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- btn_step  input  1  debounced level from the step button.
- btn_mode  input  1  debounced level from the run/pause button.
- run_len  input  N  enable pulses per burst; 0 means run indefinitely.
- count_en  output  1  one-cycle enable pulse to the Gray counter.
- count_clr  output  1  one-cycle synchronous clear pulse to the Gray counter.
- running  output  1  high while the FSM is in RUN.
- done  output  1  high while the FSM is in DONE.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - count_en=0, count_clr=0, running=0, done=0.
  - Prescaler=0 and burst counter=0.
  - Both edge-detect history registers are loaded with 1, so a button held through reset release does not produce an event.
  - Reset mid-burst aborts immediately with no further pulses.
- Edge detection:
  - step_ev = btn_step & ~step_q; mode_ev = btn_mode & ~mode_q.
  - History registers update every cycle.
  - An event lasts exactly one cycle per 0->1 transition of the level.
- Output timing:
  - All outputs are registered.
  - A command decided at clock edge k is visible from edge k through edge k+1, i.e. one cycle after the edge that samples the button high.
- IDLE:
  - step_ev alone: count_en=1 for one cycle; stay in IDLE.
  - mode_ev: go to RUN.
    - Latch run_len into len_r.
    - Clear prescaler and burst counter.
    - No count_en on the entry cycle.
  - step_ev and mode_ev in the same cycle: mode wins; step is discarded.
- RUN:
  - Prescaler increments each cycle and wraps from DIV-1 to 0.
  - On each wrap: count_en=1 and the burst counter increments, modulo 2^N.
  - The first pulse appears DIV cycles after RUN entry; pulses then repeat every DIV cycles.
  - If len_r!=0 and the wrap brings the burst counter to len_r: that pulse is issued and the FSM goes to DONE.
  - If len_r==0: the burst counter wraps silently and the FSM never self-terminates.
  - mode_ev: go to IDLE (pause). No pulse that cycle, even if the prescaler would have wrapped; the prescaler value is discarded.
  - step_ev is ignored.
  - run_len changes in RUN have no effect until the next RUN entry.
- DONE:
  - No count_en.
  - step_ev: count_clr=1 for one cycle, then IDLE.
  - mode_ev: IDLE without clear. If both occur, mode wins.
- Exclusivity: count_en and count_clr are never high in the same cycle.
- Status outputs: running and done are registered state decodes; they change on the same edge as the state.
- State encoding: 2-bit; code 3 is unreachable and recovers to IDLE.

Test Plan (DIV=4, N=8; stimulus feeds a gray_Nbits instance):
- Hold reset=0 with btn_step=1 for 3 cycles, release reset with btn_step still 1 -> no count_en and no count_clr for 10 cycles; all outputs 0.
- From IDLE, 3 separate btn_step presses -> exactly 3 one-cycle count_en pulses, each one cycle after its press edge; counter output Gray 000, 001, 011, 010.
- run_len=5, press btn_mode -> running=1; count_en at RUN-relative cycles 4, 8, 12, 16, 20; done=1 from the cycle after the 5th pulse; counter shows Gray of 5 (0x07).
- In DONE press btn_step -> one count_clr pulse; state IDLE; counter returns to 0x00.
- run_len=0, press btn_mode, run 1100 cycles, press btn_mode -> 275 pulses; the burst counter wraps past 255 with no DONE; no pulse on the pause cycle; running=0 afterwards.
- Press btn_step and btn_mode in the same cycle from IDLE -> RUN entered with no step pulse. Assert reset=0 two cycles before the 3rd RUN pulse -> no further count_en; state IDLE.
